// File: rtl/snake_pkg.sv
// Shared direction encodings, PS/2 scancodes and direction helpers for the snake direction controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_IDLE  = 8'hF0;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0.
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/turn_fifo.sv
// Circular turn queue of 2-bit directions; head feeds the applied direction, tail is the reference for new turns.
module turn_fifo #(
    parameter int QDEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] push_data,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);
    import snake_pkg::*;

    localparam logic [1:0] LAST_IDX  = 2'(QDEPTH - 1);
    localparam logic [2:0] DEPTH_CNT = 3'(QDEPTH);

    logic [1:0] mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic       do_push;
    logic       do_pop;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == LAST_IDX) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [1:0] prev_idx(input logic [1:0] i);
        return (i == 2'd0) ? LAST_IDX : i - 2'd1;
    endfunction

    assign empty   = (count == 3'd0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full queue can still take the push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign tail    = mem[prev_idx(wr_ptr)];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_pop)
                rd_ptr <= next_idx(rd_ptr);
            if (do_push)
                wr_ptr <= next_idx(wr_ptr);
            count <= count + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: synchronizes and debounces PS/2 scancodes, queues legal turns, applies them on Tick.
// Optional pause/restart keys are enabled by defining SNAKE_DIR_PAUSE_EN.
module snake_dir_ctrl #(
    parameter int STABLE_CYC = 16,
    parameter int QDEPTH     = 2
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [7:0] KeyPress,
    input  logic       Tick,
    output logic [1:0] Dir,
    output logic       Pause,
    output logic       Restart,
    output logic [2:0] QCount
);
    import snake_pkg::*;

    localparam int                CNT_W     = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(STABLE_CYC - 1);

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       stab_val;
    logic [CNT_W-1:0] stab_cnt;
    logic [7:0]       last_key;
    logic             accept;
    logic             key_evt;
    logic             is_dir;
    dir_t             evt_dir;
    dir_t             ref_dir;
    dir_t             dir_q;
    logic             pause_q;
    logic             restart_q;
    logic             fifo_push;
    logic             fifo_pop;
    logic [1:0]       q_head;
    logic [1:0]       q_tail;
    logic             q_full;
    logic             q_empty;
    logic [2:0]       q_count;

    // Synchronizer, stability counter (saturates so a held key is accepted once) and last-key register.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            sync1    <= KEY_IDLE;
            sync2    <= KEY_IDLE;
            stab_val <= KEY_IDLE;
            stab_cnt <= '0;
            last_key <= KEY_IDLE;
        end else begin
            sync1 <= KeyPress;
            sync2 <= sync1;
            if (sync2 != stab_val) begin
                stab_val <= sync2;
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            if (key_evt)
                last_key <= sync2;
        end
    end

    assign accept  = (sync2 == stab_val) && (stab_cnt == ACCEPT_AT);
    assign key_evt = accept && (sync2 != last_key);

    always_comb begin
        is_dir  = 1'b0;
        evt_dir = DIR_UP;
        case (sync2)
            KEY_UP:    begin is_dir = 1'b1; evt_dir = DIR_UP;    end
            KEY_DOWN:  begin is_dir = 1'b1; evt_dir = DIR_DOWN;  end
            KEY_LEFT:  begin is_dir = 1'b1; evt_dir = DIR_LEFT;  end
            KEY_RIGHT: begin is_dir = 1'b1; evt_dir = DIR_RIGHT; end
            default:   ;
        endcase
    end

    // The reference is taken after this cycle's pop so a turn and a Tick can share an edge.
    always_comb begin
        fifo_pop = Tick && !pause_q && !q_empty;
        if (fifo_pop)
            ref_dir = (q_count > 3'd1) ? dir_t'(q_tail) : dir_t'(q_head);
        else
            ref_dir = q_empty ? dir_q : dir_t'(q_tail);
        fifo_push = key_evt && is_dir && !pause_q && (!q_full || fifo_pop)
                    && (evt_dir != ref_dir) && (evt_dir != opposite_dir(ref_dir));
    end

    turn_fifo #(.QDEPTH(QDEPTH)) u_turn_fifo (
        .clk       (CLK),
        .rst_n     (RESETn),
        .flush     (restart_q),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (evt_dir),
        .head      (q_head),
        .tail      (q_tail),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn || restart_q)
            dir_q <= DIR_RIGHT;
        else if (fifo_pop)
            dir_q <= dir_t'(q_head);
    end

`ifdef SNAKE_DIR_PAUSE_EN
    // Restart is registered so it lasts exactly one cycle and then resets the game state.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            pause_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            restart_q <= key_evt && (sync2 == KEY_R);
            if (restart_q)
                pause_q <= 1'b0;
            else if (key_evt && (sync2 == KEY_SPACE))
                pause_q <= !pause_q;
        end
    end
`else
    assign pause_q   = 1'b0;
    assign restart_q = 1'b0;
`endif

    assign Dir     = dir_q;
    assign Pause   = pause_q;
    assign Restart = restart_q;
    assign QCount  = q_count;

endmodule

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 Parameter STABLE_CYC, default 16: number of consecutive CLK cycles a synchronized KeyPress value must hold before it is accepted.
REQ-002 Parameter QDEPTH, default 2: turn-queue depth; legal values are 1 to 4.
REQ-003 CLK  input  1  system clock; the block uses one clock.
REQ-004 RESETn  input  1  reset, synchronous, active-low.
REQ-005 KeyPress  input  8  last released scancode from PS2; asynchronous to CLK; idle value 8'hF0.
REQ-006 Tick  input  1  one-cycle game-step strobe from the game engine.
REQ-007 Dir  output  2  applied direction: UP=00, DOWN=01, LEFT=10, RIGHT=11.
REQ-008 Pause  output  1  pause level.
REQ-009 Restart  output  1  one-cycle restart strobe.
REQ-010 QCount  output  3  number of queued turns, for debug.

Function
REQ-011 KeyPress SHALL pass through a 2-flop synchronizer per bit before any use.
REQ-012 Stability filter: a candidate is accepted only after the synchronized value is unchanged for STABLE_CYC cycles; any change restarts the count.
REQ-013 Accepted value is compared with register LastKey; if different, it produces exactly one key event in the cycle of acceptance, and LastKey is updated.
REQ-014 Re-accepting a value equal to LastKey SHALL produce no event.
REQ-015 Key mapping: 1D gives UP, 1B gives DOWN, 1C gives LEFT, 23 gives RIGHT; all other codes, including F0, are ignored unless covered by REQ-024.
REQ-016 Reference direction is the queue tail if the queue is non-empty, else Dir.
REQ-017 A direction event is dropped if it equals the reference direction or its opposite (opposite = reference XOR 2'b01).
REQ-018 A direction event is dropped if the queue is full or Pause=1; otherwise it is pushed.
REQ-019 On Tick with Pause=0 and a non-empty queue: pop the head into Dir on the next edge.
REQ-020 On Tick with an empty queue, or with Pause=1: Dir is held and nothing is popped.
REQ-021 Tick and event in the same cycle: the pop is applied first; the event is then checked against the post-pop reference, and the push lands in the same edge.
REQ-022 Dir latency: Tick at edge N makes the new Dir visible after edge N+1.
REQ-023 QCount SHALL always equal the number of queue entries; the queue wraps around circularly.

Configuration
REQ-024 With SNAKE_DIR_PAUSE_EN defined: code 29 (space) toggles Pause; code 2D (R) asserts Restart for one cycle.
REQ-025 With SNAKE_DIR_PAUSE_EN defined, a Restart cycle flushes the queue, sets Dir=RIGHT and clears Pause on the next edge.
REQ-026 Without SNAKE_DIR_PAUSE_EN: Pause and Restart are tied 0, and codes 29 and 2D are ignored.

Reset
REQ-027 RESETn=0 sampled at a CLK edge SHALL set: Dir=RIGHT, Pause=0, Restart=0, queue empty (QCount=0), LastKey=8'hF0, synchronizer flops=8'hF0, stability counter=0.
REQ-028 Reset during filtering or a pending push SHALL discard that event.
REQ-029 After reset, KeyPress still at F0 SHALL produce no event.

Structure
REQ-030 Shared package snake_pkg SHALL hold the direction encodings, the scancode constants 1D/1B/1C/23/29/2D/F0, and the opposite-direction function.
REQ-031 The turn queue SHALL be a sub-module, turn_fifo (push/pop/full/empty/count, QDEPTH), instantiated once.

Verification
REQ-032 Reset, then KeyPress=1D held 20 cycles, then Tick: QCount goes 0->1->0; Dir=UP one cycle after Tick.
REQ-033 Dir=RIGHT, KeyPress=1C held 20 cycles: event dropped, QCount=0, Dir stays RIGHT.
REQ-034 KeyPress toggles 1D/1B every 5 cycles for 100 cycles, then settles at 23: at most one event, for the settled value; no event for the toggling values.
REQ-035 Dir=RIGHT, events UP then LEFT, then Tick, Tick: Dir goes UP then LEFT; a third event while the queue is full is dropped, QCount stays 2.
REQ-036 Queue={UP}, Tick and DOWN event in the same cycle: Dir=UP, DOWN dropped as opposite of UP, QCount=0.
REQ-037 SNAKE_DIR_PAUSE_EN defined, Pause=1, then 2D event: Restart high exactly one cycle, then Dir=RIGHT, Pause=0, QCount=0.
